// File: rtl/cmd_frame_rx.sv
// cmd_frame_rx
//   Turns a byte stream into address/data commands. A frame is ADDR_BYTES
//   address bytes, then DATA_BYTES data bytes, then an optional XOR checksum
//   byte. Both fields are assembled little-endian. Each pending byte is
//   consumed with a single rx_ack pulse.
//
// Ports
//   i_clk      : clock, everything on its rising edge
//   rst        : synchronous active-high reset
//   rx_data    : received byte, valid while rx_avail=1
//   rx_avail   : level, a byte is pending until acknowledged
//   rx_err     : framing error for the pending byte
//   rx_ack     : one-cycle pulse consuming the pending byte
//   cmd_en     : one-cycle pulse, cmd_addr/cmd_data hold a new command
//   cmd_addr   : command address (8*ADDR_BYTES)
//   cmd_data   : command data (8*DATA_BYTES)
//   frame_err  : one-cycle pulse, frame discarded
//   err_code   : 1 timeout, 2 checksum, 3 byte error; held until next frame_err
module cmd_frame_rx #(
  parameter int ADDR_BYTES     = 1,
  parameter int DATA_BYTES     = 2,
  parameter int CHECKSUM_EN    = 1,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic                    i_clk,
  input  logic                    rst,
  input  logic [7:0]              rx_data,
  input  logic                    rx_avail,
  input  logic                    rx_err,
  output logic                    rx_ack,
  output logic                    cmd_en,
  output logic [8*ADDR_BYTES-1:0] cmd_addr,
  output logic [8*DATA_BYTES-1:0] cmd_data,
  output logic                    frame_err,
  output logic [1:0]              err_code
);

  localparam int FRAME_LEN = ADDR_BYTES + DATA_BYTES + ((CHECKSUM_EN != 0) ? 1 : 0);
  localparam int CNT_W     = 4;
  localparam int TO_W      = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [CNT_W-1:0] FRAME_LEN_C = CNT_W'(FRAME_LEN);
  localparam logic [CNT_W-1:0] CHK_IDX_C   = CNT_W'(ADDR_BYTES + DATA_BYTES);
  localparam logic [TO_W-1:0]  TO_LAST_C   = TO_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE,
    ACK,
    WAIT,
    FINISH
  } state_t;

  state_t                  state_reg;
  logic [CNT_W-1:0]        byte_cnt_reg;
  logic [8*ADDR_BYTES-1:0] addr_shadow_reg;
  logic [8*DATA_BYTES-1:0] data_shadow_reg;
  logic [7:0]              chk_shadow_reg;
  logic [7:0]              acc_reg;
  logic                    err_seen_reg;
  logic [TO_W-1:0]         timeout_cnt_reg;

  logic                    accept;
  logic                    is_chk_byte;
  logic                    chk_good;
  logic [ADDR_BYTES-1:0]   addr_sel;
  logic [DATA_BYTES-1:0]   data_sel;

  // A byte is only taken while waiting for one; ACK and FINISH ignore rx_avail
  // so the source has a cycle to drop it after the acknowledge.
  assign accept      = rx_avail && ((state_reg == IDLE) || (state_reg == WAIT));
  assign is_chk_byte = (CHECKSUM_EN != 0) && (byte_cnt_reg == CHK_IDX_C);
  assign chk_good    = (CHECKSUM_EN == 0) || (acc_reg == chk_shadow_reg);

  // One-hot byte-lane selects derived from the position within the frame.
  generate
    for (genvar gi = 0; gi < ADDR_BYTES; gi++) begin : g_addr_sel
      assign addr_sel[gi] = (byte_cnt_reg == CNT_W'(gi));
    end
    for (genvar gi = 0; gi < DATA_BYTES; gi++) begin : g_data_sel
      assign data_sel[gi] = (byte_cnt_reg == CNT_W'(ADDR_BYTES + gi));
    end
  endgenerate

  always_ff @(posedge i_clk) begin
    if (rst) begin
      state_reg       <= IDLE;
      byte_cnt_reg    <= '0;
      addr_shadow_reg <= '0;
      data_shadow_reg <= '0;
      chk_shadow_reg  <= '0;
      acc_reg         <= '0;
      err_seen_reg    <= 1'b0;
      timeout_cnt_reg <= '0;
      rx_ack          <= 1'b0;
      cmd_en          <= 1'b0;
      cmd_addr        <= '0;
      cmd_data        <= '0;
      frame_err       <= 1'b0;
      err_code        <= 2'd0;
    end else begin
      rx_ack    <= 1'b0;
      cmd_en    <= 1'b0;
      frame_err <= 1'b0;

      // An arriving byte takes priority over a timeout expiring this cycle.
      if (accept) begin
        for (int i = 0; i < ADDR_BYTES; i++) begin
          if (addr_sel[i]) addr_shadow_reg[8*i +: 8] <= rx_data;
        end
        for (int j = 0; j < DATA_BYTES; j++) begin
          if (data_sel[j]) data_shadow_reg[8*j +: 8] <= rx_data;
        end
        if (is_chk_byte) chk_shadow_reg <= rx_data;
        else             acc_reg        <= acc_reg ^ rx_data;
        err_seen_reg    <= rx_err;
        byte_cnt_reg    <= byte_cnt_reg + CNT_W'(1);
        timeout_cnt_reg <= '0;
        rx_ack          <= 1'b1;
        state_reg       <= ACK;
      end else begin
        case (state_reg)
          ACK: begin
            if (err_seen_reg) begin
              frame_err       <= 1'b1;
              err_code        <= 2'd3;
              byte_cnt_reg    <= '0;
              acc_reg         <= '0;
              timeout_cnt_reg <= '0;
              state_reg       <= IDLE;
            end else if (byte_cnt_reg != FRAME_LEN_C) begin
              state_reg <= WAIT;
            end else begin
              // Results are registered here so they are visible during FINISH.
              if (chk_good) begin
                cmd_en   <= 1'b1;
                cmd_addr <= addr_shadow_reg;
                cmd_data <= data_shadow_reg;
              end else begin
                frame_err <= 1'b1;
                err_code  <= 2'd2;
              end
              byte_cnt_reg <= '0;
              acc_reg      <= '0;
              state_reg    <= FINISH;
            end
          end
          WAIT: begin
            if (timeout_cnt_reg == TO_LAST_C) begin
              frame_err       <= 1'b1;
              err_code        <= 2'd1;
              byte_cnt_reg    <= '0;
              acc_reg         <= '0;
              timeout_cnt_reg <= '0;
              state_reg       <= IDLE;
            end else begin
              timeout_cnt_reg <= timeout_cnt_reg + TO_W'(1);
            end
          end
          FINISH: state_reg <= IDLE;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cmd_frame_rx.sv
// Testbench for cmd_frame_rx: directed frames plus randomized frames checked
// against a frame-level reference (field packing, XOR checksum, error priority).
module tb_cmd_frame_rx;

  localparam int TO = 16;

  logic        i_clk = 1'b0;
  logic        rst;
  logic [7:0]  rx_data;
  logic        rx_avail;
  logic        rx_err;
  logic        rx_ack;
  logic        cmd_en;
  logic [7:0]  cmd_addr;
  logic [15:0] cmd_data;
  logic        frame_err;
  logic [1:0]  err_code;

  logic [7:0]  rx2_data;
  logic        rx2_avail;
  logic        rx2_err;
  logic        rx2_ack;
  logic        cmd2_en;
  logic [15:0] cmd2_addr;
  logic [31:0] cmd2_data;
  logic        frame2_err;
  logic [1:0]  err2_code;

  always #5 i_clk = ~i_clk;

  cmd_frame_rx #(
    .ADDR_BYTES(1), .DATA_BYTES(2), .CHECKSUM_EN(1), .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(i_clk), .rst(rst), .rx_data(rx_data), .rx_avail(rx_avail),
    .rx_err(rx_err), .rx_ack(rx_ack), .cmd_en(cmd_en), .cmd_addr(cmd_addr),
    .cmd_data(cmd_data), .frame_err(frame_err), .err_code(err_code)
  );

  cmd_frame_rx #(
    .ADDR_BYTES(2), .DATA_BYTES(4), .CHECKSUM_EN(0), .TIMEOUT_CYCLES(TO)
  ) dut2 (
    .i_clk(i_clk), .rst(rst), .rx_data(rx2_data), .rx_avail(rx2_avail),
    .rx_err(rx2_err), .rx_ack(rx2_ack), .cmd_en(cmd2_en), .cmd_addr(cmd2_addr),
    .cmd_data(cmd2_data), .frame_err(frame2_err), .err_code(err2_code)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [23:0] cmd_q[$];
  int          cmd_cyc_q[$];
  logic [1:0]  err_q[$];
  int          ack_cnt = 0;
  int          both_viol = 0;
  int          hold_viol = 0;
  logic [23:0] prev_out = '0;
  logic        was_rst = 1'b1;
  logic [23:0] last_good = '0;

  int          cmd2_cnt = 0;
  int          err2_cnt = 0;
  logic [47:0] cmd2_val = '0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  always @(negedge i_clk) begin
    if (rx_ack) ack_cnt <= ack_cnt + 1;
    if (cmd_en) begin
      cmd_q.push_back({cmd_addr, cmd_data});
      cmd_cyc_q.push_back(cyc);
    end
    if (frame_err) err_q.push_back(err_code);
    if (cmd_en && frame_err) both_viol <= both_viol + 1;
    if (!rst && !was_rst && !cmd_en && ({cmd_addr, cmd_data} !== prev_out))
      hold_viol <= hold_viol + 1;
    prev_out <= {cmd_addr, cmd_data};
    was_rst  <= rst;
    if (cmd2_en) begin
      cmd2_cnt <= cmd2_cnt + 1;
      cmd2_val <= {cmd2_addr, cmd2_data};
    end
    if (frame2_err) err2_cnt <= err2_cnt + 1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] d, input logic e, output int ack_cyc);
    logic got;
    got     = 1'b0;
    ack_cyc = 0;
    rx_data = d; rx_err = e; rx_avail = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      if (rx_ack) begin
        got     = 1'b1;
        ack_cyc = cyc;
      end
    end
    chk("ack_seen", 64'(got), 64'd1);
    @(posedge i_clk); #1;
    rx_avail = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
  endtask

  task automatic send_byte2(input logic [7:0] d);
    logic got;
    got = 1'b0;
    rx2_data = d; rx2_err = 1'b0; rx2_avail = 1'b1;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge i_clk);
      if (rx2_ack) got = 1'b1;
    end
    chk("ack2_seen", 64'(got), 64'd1);
    @(posedge i_clk); #1;
    rx2_avail = 1'b0; rx2_data = 8'h00;
  endtask

  // Sends one frame (truncated at the erroring byte) and checks the outcome.
  task automatic run_frame(input string tag, input logic [7:0] b[4], input int err_idx,
                           input int g[4]);
    int          n;
    int          a0;
    int          last_ack;
    int          k;
    logic [7:0]  x;
    logic        exp_cmd;
    logic [23:0] exp_val;
    logic [1:0]  exp_code;
    n        = (err_idx >= 0) ? err_idx + 1 : 4;
    a0       = ack_cnt;
    last_ack = 0;
    cmd_q.delete(); cmd_cyc_q.delete(); err_q.delete();
    for (int i = 0; i < n; i++) begin
      repeat (g[i]) @(posedge i_clk);
      #1;
      send_byte(b[i], (i == err_idx), last_ack);
    end
    x        = b[0] ^ b[1] ^ b[2];
    exp_cmd  = (err_idx < 0) && (x == b[3]);
    exp_code = (err_idx >= 0) ? 2'd3 : 2'd2;
    exp_val  = {b[0], b[2], b[1]};
    k = 0;
    while (k < 10 && cmd_q.size() == 0 && err_q.size() == 0) begin
      @(posedge i_clk); #1;
      k++;
    end
    repeat (2) @(posedge i_clk);
    #1;
    chk({tag, "_ncmd"}, 64'(cmd_q.size()), exp_cmd ? 64'd1 : 64'd0);
    chk({tag, "_nerr"}, 64'(err_q.size()), exp_cmd ? 64'd0 : 64'd1);
    if (exp_cmd) begin
      last_good = exp_val;
      if (cmd_q.size() == 1) begin
        chk({tag, "_cmd"}, 64'(cmd_q[0]), 64'(exp_val));
        chk({tag, "_latency"}, 64'(cmd_cyc_q[0] - last_ack), 64'd1);
      end
    end else if (err_q.size() == 1) begin
      chk({tag, "_code"}, 64'(err_q[0]), 64'(exp_code));
    end
    chk({tag, "_hold"}, 64'({cmd_addr, cmd_data}), 64'(last_good));
    chk({tag, "_acks"}, 64'(ack_cnt - a0), 64'(n));
  endtask

  initial begin
    logic [7:0]  b[4];
    int          g[4];
    logic [7:0]  b6[6];
    logic [47:0] exp2;
    int          dummy;
    int          c0;
    int          eidx;

    rst = 1'b1;
    rx_data = 8'h00; rx_avail = 1'b0; rx_err = 1'b0;
    rx2_data = 8'h00; rx2_avail = 1'b0; rx2_err = 1'b0;
    g = '{0, 0, 0, 0};
    repeat (4) @(posedge i_clk);
    #1;
    rst = 1'b0;
    chk("reset_pulses", 64'({rx_ack, cmd_en, frame_err}), 64'd0);
    chk("reset_outs", 64'({cmd_addr, cmd_data, err_code}), 64'd0);

    b = '{8'h12, 8'h34, 8'h56, 8'h70};
    run_frame("good", b, -1, g);
    b = '{8'h12, 8'h34, 8'h56, 8'h71};
    run_frame("badsum", b, -1, g);

    // Timeout after two bytes: no error after 15 idle WAIT cycles, error after 16.
    err_q.delete(); cmd_q.delete();
    send_byte(8'h12, 1'b0, dummy);
    send_byte(8'h34, 1'b0, dummy);
    repeat (15) @(posedge i_clk);
    #1;
    chk("to_early", 64'(err_q.size()), 64'd0);
    repeat (2) @(posedge i_clk);
    #1;
    chk("to_fire", 64'(err_q.size()), 64'd1);
    if (err_q.size() == 1) chk("to_code", 64'(err_q[0]), 64'd1);
    chk("to_nocmd", 64'(cmd_q.size()), 64'd0);
    b = '{8'hAA, 8'h01, 8'h02, 8'hA9};
    run_frame("after_to", b, -1, g);

    // A byte arriving in the last allowed WAIT cycle still belongs to the frame.
    b = '{8'h5A, 8'h11, 8'h22, 8'h69};
    g = '{0, 15, 0, 15};
    run_frame("edge_gap", b, -1, g);
    g = '{0, 0, 0, 0};

    b = '{8'h12, 8'h34, 8'h56, 8'h70};
    run_frame("byte_err", b, 1, g);

    // Mid-frame reset.
    cmd_q.delete(); err_q.delete();
    send_byte(8'h77, 1'b0, dummy);
    send_byte(8'h88, 1'b0, dummy);
    rst = 1'b1;
    @(posedge i_clk); #1;
    rst = 1'b0;
    last_good = '0;
    chk("midrst_outs", 64'({cmd_addr, cmd_data, err_code}), 64'd0);
    chk("midrst_pulses", 64'({rx_ack, cmd_en, frame_err}), 64'd0);
    repeat (TO + 4) @(posedge i_clk);
    #1;
    chk("midrst_silent", 64'(cmd_q.size() + err_q.size()), 64'd0);
    b = '{8'h3C, 8'hC3, 8'h0F, 8'hF0};
    run_frame("after_rst", b, -1, g);

    // Randomized frames.
    for (int f = 0; f < 40; f++) begin
      for (int i = 0; i < 3; i++) b[i] = 8'($urandom);
      b[3] = b[0] ^ b[1] ^ b[2];
      if ($urandom_range(3) == 0) b[3] = b[3] ^ 8'($urandom_range(1, 255));
      eidx = ($urandom_range(7) == 0) ? int'($urandom_range(3)) : -1;
      for (int i = 0; i < 4; i++)
        g[i] = ($urandom_range(9) == 0) ? 15 : int'($urandom_range(0, 3));
      run_frame("rand", b, eidx, g);
    end

    // Wide configuration, no checksum.
    b6 = '{8'h01, 8'h02, 8'hA0, 8'hB0, 8'hC0, 8'hD0};
    for (int f = 0; f < 4; f++) begin
      if (f > 0) for (int i = 0; i < 6; i++) b6[i] = 8'($urandom);
      exp2 = {b6[1], b6[0], b6[5], b6[4], b6[3], b6[2]};
      c0 = cmd2_cnt;
      for (int i = 0; i < 6; i++) send_byte2(b6[i]);
      for (int k = 0; k < 10 && cmd2_cnt == c0; k++) begin
        @(posedge i_clk); #1;
      end
      chk("wide_ncmd", 64'(cmd2_cnt - c0), 64'd1);
      chk("wide_cmd", 64'(cmd2_val), 64'(exp2));
    end
    chk("wide_noerr", 64'(err2_cnt), 64'd0);

    chk("cmd_and_err_same_cycle", 64'(both_viol), 64'd0);
    chk("outputs_change_without_cmd_en", 64'(hold_viol), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/cmd_frame_rx.md
CMD_FRAME_RX -- requirements
Module: cmd_frame_rx

Interface
REQ-001 SHALL have parameter ADDR_BYTES, default 1, number of address bytes per frame (1..4).
REQ-002 SHALL have parameter DATA_BYTES, default 2, number of data bytes per frame (1..4).
REQ-003 SHALL have parameter CHECKSUM_EN, default 1, meaning 1 = frame ends with an XOR checksum byte.
REQ-004 SHALL have parameter TIMEOUT_CYCLES, default 100000, the inter-byte idle limit inside a frame (>=2).
REQ-005 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-007 SHALL have port rx_data, input, 8, the received byte, valid while rx_avail=1.
REQ-008 SHALL have port rx_avail, input, 1, a level meaning a byte is pending; held until acknowledged.
REQ-009 SHALL have port rx_err, input, 1, the framing-error flag for the pending byte, qualified by rx_avail.
REQ-010 SHALL have port rx_ack, output, 1, a one-cycle pulse that consumes the pending byte.
REQ-011 SHALL have port cmd_en, output, 1, a one-cycle pulse marking a valid command.
REQ-012 SHALL have port cmd_addr, output, 8*ADDR_BYTES, the command address.
REQ-013 SHALL have port cmd_data, output, 8*DATA_BYTES, the command data.
REQ-014 SHALL have port frame_err, output, 1, a one-cycle pulse marking a discarded frame.
REQ-015 SHALL have port err_code, output, 2, the error cause, where 1 = timeout, 2 = checksum, 3 = byte error; it holds until the next frame_err.

Function
REQ-016 SHALL implement the frame as ADDR_BYTES address bytes, then DATA_BYTES data bytes, then 1 checksum byte when CHECKSUM_EN=1.
REQ-017 SHALL assemble address and data fields little-endian: the first byte of each field is bits [7:0], and later bytes fill the higher bytes.
REQ-018 SHALL define the checksum as the XOR of all address and data bytes; the received checksum byte must equal it.
REQ-019 SHALL use states IDLE (await first byte), ACK (rx_ack high), WAIT (await next byte) and FINISH (emit result).
REQ-020 SHALL accept a byte in IDLE or WAIT when rx_avail=1: the byte is captured into shadow registers and the next cycle is ACK with rx_ack=1.
REQ-021 SHALL never sample rx_avail in the ACK state, so there is exactly one rx_ack per byte with at least one low cycle between pulses.
REQ-022 SHALL go from ACK to WAIT if bytes remain in the frame, else to FINISH.
REQ-023 SHALL pulse cmd_en=1 in FINISH when the checksum is good or CHECKSUM_EN=0, and load cmd_addr/cmd_data from the shadow registers in that same cycle; FINISH then goes to IDLE.
REQ-024 SHALL, on a checksum mismatch in FINISH, pulse frame_err with err_code=2 instead, leave cmd_addr/cmd_data unchanged, and go to IDLE.
REQ-025 SHALL give a latency of 2 cycles from sampling the final byte to cmd_en.
REQ-026 SHALL change cmd_addr/cmd_data only on a cmd_en cycle.
REQ-027 SHALL, on an accepted byte with rx_err=1 in any state: still acknowledge it, discard the frame, pulse frame_err with err_code=3 after the ACK cycle, and go to IDLE.
REQ-028 SHALL keep a timeout counter that counts only in WAIT and clears on every accepted byte.
REQ-029 SHALL, after TIMEOUT_CYCLES consecutive WAIT cycles with no byte, pulse frame_err with err_code=1 and go to IDLE.
REQ-030 SHALL let an arriving byte win over a timeout expiring in the same cycle.
REQ-031 SHALL never time out in IDLE, and IDLE SHALL wait indefinitely.
REQ-032 SHALL never assert cmd_en and frame_err in the same cycle.

Reset
REQ-033 SHALL, when rst=1, force state IDLE and clear rx_ack, cmd_en, frame_err, err_code, cmd_addr, cmd_data, the byte counter, the shadow registers, the checksum accumulator and the timeout counter to 0.
REQ-034 SHALL discard any partial frame on a mid-frame reset, with no cmd_en or frame_err pulse for it.
REQ-035 SHALL let the first byte after rst deasserts start a new frame.

Verification
Default parameters with TIMEOUT_CYCLES=16 unless stated.
REQ-036 SHALL cover: bytes 0x12,0x34,0x56 with checksum 0x70 -> cmd_en for one cycle, cmd_addr=0x12, cmd_data=0x5634, 4 rx_ack pulses.
REQ-037 SHALL cover: the same frame with checksum 0x71 -> frame_err, err_code=2, no cmd_en, outputs keep their prior values.
REQ-038 SHALL cover: 0x12,0x34 then 16 idle cycles -> frame_err with err_code=1; a following good frame 0xAA,0x01,0x02,0xA9 -> cmd_addr=0xAA, cmd_data=0x0201.
REQ-039 SHALL cover: rx_err=1 on the second byte -> that byte is acknowledged, frame_err with err_code=3, no cmd_en.
REQ-040 SHALL cover: rst=1 for one cycle after two bytes, then a full good frame -> outputs are 0 after reset, and the next frame decodes correctly with no pulse for the aborted one.
REQ-041 SHALL cover: ADDR_BYTES=2, DATA_BYTES=4, CHECKSUM_EN=0 with bytes 01,02,A0,B0,C0,D0 -> cmd_addr=0x0201, cmd_data=0xD0C0B0A0.
